duck_flock_drawer: RTL and testbench

//  Multi-sprite successor to the single-duck drawer. Animates N_DUCKS independent ducks (fly/bob, hit, fall, respawn)
//  and generates per-pixel addresses into one shared external sprite ROM.

---
 rtl/duck_pkg.sv | 35 +++
 rtl/duck_flock_drawer_channel.sv | 142 ++++++++++++++
 rtl/duck_flock_drawer.sv | 188 ++++++++++++++++++
 tb/tb_duck_flock_drawer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/duck_pkg.sv
// Shared types and helpers for the duck flock drawer: FSM state encoding,
// screen constants and small geometry helpers.
package duck_pkg;

   typedef enum logic [1:0] {
      ST_FLY  = 2'd0,
      ST_HIT  = 2'd1,
      ST_FALL = 2'd2,
      ST_RESP = 2'd3
   } duck_state_e;

   localparam int H_ACT       = 640;
   localparam int V_ACT       = 480;
   localparam int FALL_STEP   = 2;
   localparam int SPAWN_Y_MOD = 320;

   // Spawn column of duck idx; mirrored ducks start just off the left edge.
   function automatic logic signed [10:0] spawn_x(input int idx, input int x0, input int x_spc,
                                                  input int spr_w, input bit mirror);
      return mirror ? 11'(-spr_w - idx * x_spc) : 11'(x0 + idx * x_spc);
   endfunction

   // Spawn row of duck idx, folded into the upper part of the screen.
   function automatic logic signed [9:0] spawn_y(input int idx, input int y0, input int y_spc);
      return 10'((y0 + idx * y_spc) % SPAWN_Y_MOD);
   endfunction

   // Signed point-in-rectangle test, origin inclusive, far edges exclusive.
   function automatic logic in_box(input logic signed [11:0] px, input logic signed [11:0] py,
                                   input logic signed [11:0] ox, input logic signed [11:0] oy,
                                   input logic signed [11:0] w,  input logic signed [11:0] h);
      return (ox <= px) && (px < ox + w) && (oy <= py) && (py < oy + h);
   endfunction

endpackage

// File: rtl/duck_flock_drawer_channel.sv
// One duck: fly/bob, hit freeze, fall and respawn FSM plus the cover flag
// for the current pixel. Mirrored flight is selected per instance.
module duck_channel
   import duck_pkg::*;
#(
   parameter int                 SPR_W      = 46,
   parameter int                 SPR_H      = 40,
   parameter int                 BOB_LEN    = 30,
   parameter int                 HIT_TICKS  = 20,
   parameter int                 RESP_TICKS = 60,
   parameter logic signed [10:0] SPAWN_X    = 11'sd594,
   parameter logic signed [9:0]  SPAWN_Y    = 10'sd150,
   parameter bit                 MIRROR     = 1'b0
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               x_tick_i,
   input  logic               y_tick_i,
   input  logic               hit_i,
   input  logic [9:0]         hcount_i,
   input  logic [9:0]         vcount_i,
   output logic signed [10:0] x_o,
   output logic signed [9:0]  y_o,
   output logic [1:0]         state_o,
   output logic               cover_o
);

   localparam logic signed [11:0] W_S       = 12'(SPR_W);
   localparam logic signed [11:0] H_S       = 12'(SPR_H);
   localparam logic signed [11:0] W_NEG     = 12'(-SPR_W);
   localparam logic signed [11:0] H_MAX     = 12'(H_ACT);
   localparam logic signed [9:0]  V_MAX     = 10'(V_ACT);
   localparam logic signed [9:0]  FALL_D    = 10'(FALL_STEP);
   localparam logic [7:0]         BOB_LAST  = 8'(BOB_LEN - 1);
   localparam logic [7:0]         HIT_LAST  = 8'(HIT_TICKS - 1);
   localparam logic [7:0]         RESP_LAST = 8'(RESP_TICKS - 1);

   duck_state_e        state_q;
   logic signed [10:0] pos_x_q;
   logic signed [9:0]  pos_y_q;
   logic               dir_neg_q;
   logic [7:0]         bob_q;
   logic [7:0]         tcnt_q;
   logic signed [10:0] x_next_d;
   logic signed [9:0]  y_bob_d;
   logic signed [9:0]  y_fall_d;
   logic signed [11:0] x_wide_s;
   logic signed [11:0] y_wide_s;
   logic signed [11:0] x_step_s;
   logic signed [11:0] hc_s;
   logic signed [11:0] vc_s;

   assign x_wide_s = {pos_x_q[10], pos_x_q};
   assign y_wide_s = {{2{pos_y_q[9]}}, pos_y_q};
   assign hc_s     = {2'b00, hcount_i};
   assign vc_s     = {2'b00, vcount_i};
   assign y_bob_d  = dir_neg_q ? (pos_y_q - 10'sd1) : (pos_y_q + 10'sd1);
   assign y_fall_d = pos_y_q + FALL_D;

   // Next column on a horizontal step, wrapping once fully off-screen.
   always_comb begin
      if (MIRROR) begin
         x_step_s = x_wide_s + 12'sd1;
         x_next_d = (x_step_s > H_MAX) ? 11'(W_NEG) : x_step_s[10:0];
      end else begin
         x_step_s = x_wide_s - 12'sd1;
         x_next_d = (x_step_s < W_NEG) ? 11'(H_MAX) : x_step_s[10:0];
      end
   end

   // Duck FSM with position, bob and tick counters; a hit beats a coincident move.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_FLY;
         pos_x_q   <= SPAWN_X;
         pos_y_q   <= SPAWN_Y;
         dir_neg_q <= 1'b0;
         bob_q     <= 8'd0;
         tcnt_q    <= 8'd0;
      end else begin
         case (state_q)
            ST_FLY: begin
               if (hit_i) begin
                  state_q <= ST_HIT;
                  tcnt_q  <= 8'd0;
               end else begin
                  if (x_tick_i) pos_x_q <= x_next_d;
                  if (y_tick_i) begin
                     pos_y_q <= y_bob_d;
                     if (bob_q == BOB_LAST) begin
                        bob_q     <= 8'd0;
                        dir_neg_q <= ~dir_neg_q;
                     end else begin
                        bob_q <= bob_q + 8'd1;
                     end
                  end
               end
            end
            ST_HIT: begin
               if (y_tick_i) begin
                  if (tcnt_q == HIT_LAST) begin
                     state_q <= ST_FALL;
                     tcnt_q  <= 8'd0;
                  end else begin
                     tcnt_q <= tcnt_q + 8'd1;
                  end
               end
            end
            ST_FALL: begin
               if (y_tick_i) begin
                  pos_y_q <= y_fall_d;
                  if (y_fall_d >= V_MAX) begin
                     state_q <= ST_RESP;
                     tcnt_q  <= 8'd0;
                  end
               end
            end
            ST_RESP: begin
               if (y_tick_i) begin
                  if (tcnt_q == RESP_LAST) begin
                     state_q   <= ST_FLY;
                     tcnt_q    <= 8'd0;
                     pos_x_q   <= SPAWN_X;
                     pos_y_q   <= SPAWN_Y;
                     dir_neg_q <= 1'b0;
                     bob_q     <= 8'd0;
                  end else begin
                     tcnt_q <= tcnt_q + 8'd1;
                  end
               end
            end
            default: state_q <= ST_FLY;
         endcase
      end
   end

   assign x_o     = pos_x_q;
   assign y_o     = pos_y_q;
   assign state_o = state_q;
   assign cover_o = (state_q != ST_RESP) && in_box(hc_s, vc_s, x_wide_s, y_wide_s, W_S, H_S);

endmodule

// File: rtl/duck_flock_drawer.sv
// Multi-duck sprite drawer: shared prescalers, shot arbitration, priority
// select and a 3-stage pixel pipeline into one external synchronous ROM.
// Optional feature: define DUCK_MIRROR_EN for mirrored left-to-right odd ducks.
module duck_flock_drawer
   import duck_pkg::*;
#(
   parameter int                 N_DUCKS    = 4,
   parameter int                 SPR_W      = 46,
   parameter int                 SPR_H      = 40,
   parameter int                 ADDR_W     = 11,
   parameter int                 COLOR_W    = 6,
   parameter logic [COLOR_W-1:0] TRANSP     = '0,
   parameter int                 X_DIV      = 60000,
   parameter int                 Y_DIV      = 260000,
   parameter int                 BOB_LEN    = 30,
   parameter int                 HIT_TICKS  = 20,
   parameter int                 RESP_TICKS = 60,
   parameter int                 X0         = 594,
   parameter int                 Y0         = 150,
   parameter int                 X_SPC      = 120,
   parameter int                 Y_SPC      = 60
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [9:0]         hcount,
   input  logic [9:0]         vcount,
   input  logic               shot_valid,
   input  logic [9:0]         shot_x,
   input  logic [9:0]         shot_y,
   output logic [ADDR_W-1:0]  rom_addr,
   input  logic [COLOR_W-1:0] rom_data,
   output logic [COLOR_W-1:0] pixel_data,
   output logic               draw,
   output logic [2:0]         draw_id,
   output logic               hit_pulse,
   output logic [2:0]         hit_id,
   output logic [N_DUCKS-1:0] alive
);

`ifdef DUCK_MIRROR_EN
   localparam bit MIRROR_EN = 1'b1;
`else
   localparam bit MIRROR_EN = 1'b0;
`endif

   localparam logic signed [11:0] W_S = 12'(SPR_W);
   localparam logic signed [11:0] H_S = 12'(SPR_H);

   logic [31:0]        x_cnt_q, y_cnt_q;
   logic               x_tick_s, y_tick_s;
   logic signed [10:0] ch_x_s  [N_DUCKS];
   logic signed [9:0]  ch_y_s  [N_DUCKS];
   logic [1:0]         ch_st_s [N_DUCKS];
   logic [N_DUCKS-1:0] cover_s, shootable_s, hit_vec_s;
   logic signed [11:0] shx_s, shy_s, hc_s, vc_s;
   logic               hit_any_s, sel_s, mir_s, opaque_s;
   logic [2:0]         hit_idx_s, sel_id_s;
   logic signed [10:0] sx_s;
   logic signed [9:0]  sy_s;
   logic signed [11:0] row_s, col_raw_s, col_s;
   logic [23:0]        addr_wide_s;
   logic [ADDR_W-1:0]  rom_addr_d;
   logic [ADDR_W-1:0]  rom_addr_q;
   logic               sel1_q, sel2_q, draw_q, hit_pulse_q;
   logic [2:0]         id1_q, id2_q, draw_id_q, hit_id_q;
   logic [COLOR_W-1:0] pixel_q;

   assign x_tick_s = (x_cnt_q == 32'(X_DIV - 1));
   assign y_tick_s = (y_cnt_q == 32'(Y_DIV - 1));
   assign shx_s    = {2'b00, shot_x};
   assign shy_s    = {2'b00, shot_y};
   assign hc_s     = {2'b00, hcount};
   assign vc_s     = {2'b00, vcount};

   // Shared horizontal and vertical step prescalers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_cnt_q <= 32'd0;
         y_cnt_q <= 32'd0;
      end else begin
         x_cnt_q <= x_tick_s ? 32'd0 : x_cnt_q + 32'd1;
         y_cnt_q <= y_tick_s ? 32'd0 : y_cnt_q + 32'd1;
      end
   end

   for (genvar gi = 0; gi < N_DUCKS; gi++) begin : g_duck
      localparam bit MIR = MIRROR_EN && (gi % 2 == 1);
      duck_channel #(
         .SPR_W      (SPR_W),
         .SPR_H      (SPR_H),
         .BOB_LEN    (BOB_LEN),
         .HIT_TICKS  (HIT_TICKS),
         .RESP_TICKS (RESP_TICKS),
         .SPAWN_X    (spawn_x(gi, X0, X_SPC, SPR_W, MIR)),
         .SPAWN_Y    (spawn_y(gi, Y0, Y_SPC)),
         .MIRROR     (MIR)
      ) u_ch (
         .clk      (clk),
         .reset    (reset),
         .x_tick_i (x_tick_s),
         .y_tick_i (y_tick_s),
         .hit_i    (hit_vec_s[gi]),
         .hcount_i (hcount),
         .vcount_i (vcount),
         .x_o      (ch_x_s[gi]),
         .y_o      (ch_y_s[gi]),
         .state_o  (ch_st_s[gi]),
         .cover_o  (cover_s[gi])
      );
      // Test runs on the current (pre-tick) position of each flying duck.
      assign shootable_s[gi] = (ch_st_s[gi] == ST_FLY) &&
                               in_box(shx_s, shy_s, {ch_x_s[gi][10], ch_x_s[gi]},
                                      {{2{ch_y_s[gi][9]}}, ch_y_s[gi]}, W_S, H_S);
      assign alive[gi] = (ch_st_s[gi] == ST_FLY);
   end

   // Lowest-index shootable duck takes the shot; one-hot hit to that channel.
   always_comb begin
      hit_any_s = 1'b0;
      hit_idx_s = 3'd0;
      hit_vec_s = '0;
      for (int i = N_DUCKS - 1; i >= 0; i--) begin
         hit_any_s = shootable_s[i] ? 1'b1 : hit_any_s;
         hit_idx_s = shootable_s[i] ? 3'(i) : hit_idx_s;
      end
      for (int i = 0; i < N_DUCKS; i++) begin
         hit_vec_s[i] = shot_valid && hit_any_s && (hit_idx_s == 3'(i));
      end
   end

   // Pick the lowest-index covering duck and form its ROM address from coordinates.
   always_comb begin
      sel_s    = 1'b0;
      sel_id_s = 3'd0;
      sx_s     = '0;
      sy_s     = '0;
      for (int i = N_DUCKS - 1; i >= 0; i--) begin
         sel_s    = cover_s[i] ? 1'b1 : sel_s;
         sel_id_s = cover_s[i] ? 3'(i) : sel_id_s;
         sx_s     = cover_s[i] ? ch_x_s[i] : sx_s;
         sy_s     = cover_s[i] ? ch_y_s[i] : sy_s;
      end
      mir_s       = MIRROR_EN && sel_id_s[0];
      row_s       = vc_s - {{2{sy_s[9]}}, sy_s};
      col_raw_s   = hc_s - {sx_s[10], sx_s};
      col_s       = mir_s ? (W_S - 12'sd1 - col_raw_s) : col_raw_s;
      addr_wide_s = 24'(row_s) * 24'(SPR_W) + 24'(col_s);
      rom_addr_d  = sel_s ? addr_wide_s[ADDR_W-1:0] : '0;
   end

   // A transparent pixel of the selected duck hides anything behind it.
   assign opaque_s = sel2_q && (rom_data != TRANSP);

   // Pixel pipeline stages S1..S3 and the registered hit report.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rom_addr_q  <= '0;
         sel1_q      <= 1'b0;
         id1_q       <= 3'd0;
         sel2_q      <= 1'b0;
         id2_q       <= 3'd0;
         draw_q      <= 1'b0;
         pixel_q     <= '0;
         draw_id_q   <= 3'd0;
         hit_pulse_q <= 1'b0;
         hit_id_q    <= 3'd0;
      end else begin
         rom_addr_q  <= rom_addr_d;
         sel1_q      <= sel_s;
         id1_q       <= sel_id_s;
         sel2_q      <= sel1_q;
         id2_q       <= id1_q;
         draw_q      <= opaque_s;
         pixel_q     <= opaque_s ? rom_data : '0;
         draw_id_q   <= id2_q;
         hit_pulse_q <= shot_valid && hit_any_s;
         hit_id_q    <= (shot_valid && hit_any_s) ? hit_idx_s : hit_id_q;
      end
   end

   assign rom_addr   = rom_addr_q;
   assign pixel_data = pixel_q;
   assign draw       = draw_q;
   assign draw_id    = draw_id_q;
   assign hit_pulse  = hit_pulse_q;
   assign hit_id     = hit_id_q;

endmodule

// File: tb/tb_duck_flock_drawer.sv
// Directed bench for duck_flock_drawer. dut_a: frozen ducks at (100,100)+i*30
// for draw/shot checks; dut_b: fast prescalers for motion, hit and respawn.
module tb_duck_flock_drawer;
   import duck_pkg::*;

   logic        clk;
   logic        rst_a, rst_b;
   logic [9:0]  hc_a, vc_a, sx_a, sy_a, hc_b, vc_b, sx_b, sy_b;
   logic        sv_a, sv_b;
   logic [10:0] rom_addr_a, rom_addr_b;
   logic [5:0]  rom_data_a;
   logic [5:0]  rom_data_b;
   logic [5:0]  pix_a, pix_b;
   logic        draw_a, draw_b, hp_a, hp_b;
   logic [2:0]  did_a, did_b, hid_a, hid_b;
   logic [3:0]  alive_a, alive_b;
   logic [10:0] hot_addr;
   logic [5:0]  hot_val;
   int          n_checks;
   int          n_errors;

   duck_flock_drawer #(
      .X_DIV(100000), .Y_DIV(100000), .X0(100), .Y0(100), .X_SPC(30), .Y_SPC(0)
   ) dut_a (
      .clk(clk), .reset(rst_a), .hcount(hc_a), .vcount(vc_a),
      .shot_valid(sv_a), .shot_x(sx_a), .shot_y(sy_a),
      .rom_addr(rom_addr_a), .rom_data(rom_data_a), .pixel_data(pix_a),
      .draw(draw_a), .draw_id(did_a), .hit_pulse(hp_a), .hit_id(hid_a), .alive(alive_a)
   );

   duck_flock_drawer #(
      .X_DIV(4), .Y_DIV(8), .HIT_TICKS(2), .RESP_TICKS(3)
   ) dut_b (
      .clk(clk), .reset(rst_b), .hcount(hc_b), .vcount(vc_b),
      .shot_valid(sv_b), .shot_x(sx_b), .shot_y(sy_b),
      .rom_addr(rom_addr_b), .rom_data(rom_data_b), .pixel_data(pix_b),
      .draw(draw_b), .draw_id(did_b), .hit_pulse(hp_b), .hit_id(hid_b), .alive(alive_b)
   );

   always #5 clk = ~clk;

   // Synchronous ROM model for dut_a: one hot address, opaque 6'h3F elsewhere.
   always @(posedge clk) rom_data_a <= (rom_addr_a == hot_addr) ? hot_val : 6'h3F;

   assign rom_data_b = 6'h00;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic adv(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic shoot_a(input string tag, input int x, input int y, input logic exp_p,
                          input int exp_id, input logic [3:0] exp_alive);
      sv_a = 1'b1; sx_a = 10'(x); sy_a = 10'(y);
      adv(1);
      sv_a = 1'b0;
      check({tag, "_pulse"}, 32'(hp_a), 32'(exp_p));
      if (exp_p) check({tag, "_id"}, 32'(hid_a), exp_id);
      check({tag, "_alive"}, 32'(alive_a), 32'(exp_alive));
      adv(1);
      check({tag, "_pulse_clr"}, 32'(hp_a), 0);
   endtask

   task automatic pix_a_at(input string tag, input int h, input int v, input int exp_addr,
                           input logic exp_draw, input int exp_pix, input int exp_id);
      hc_a = 10'(h); vc_a = 10'(v);
      adv(1);
      check({tag, "_addr"}, 32'(rom_addr_a), exp_addr);
      adv(2);
      check({tag, "_draw"}, 32'(draw_a), 32'(exp_draw));
      check({tag, "_pix"}, 32'(pix_a), exp_pix);
      if (exp_draw) check({tag, "_id"}, 32'(did_a), exp_id);
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      clk = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
      hc_a = '0; vc_a = '0; sx_a = '0; sy_a = '0; sv_a = 1'b0;
      hc_b = '0; vc_b = '0; sx_b = '0; sy_b = '0; sv_b = 1'b0;
      hot_addr = 11'd93; hot_val = 6'h15;
      #12;
      check("rst_alive", 32'(alive_a), 15);
      check("rst_addr", 32'(rom_addr_a), 0);
      check("rst_draw", 32'(draw_a), 0);
      check("rst_hit", 32'(hp_a), 0);
      @(negedge clk); rst_a = 1'b1;

      pix_a_at("px93", 101, 102, 93, 1'b1, 21, 0);
      hot_val = 6'h00;
      pix_a_at("transp", 101, 102, 93, 1'b0, 0, 0);
      hot_val = 6'h15;
      pix_a_at("corner", 145, 139, 1839, 1'b1, 63, 0);
      pix_a_at("below", 100, 140, 0, 1'b0, 0, 0);
      pix_a_at("overlap", 135, 110, 495, 1'b1, 63, 0);

      shoot_a("shot1", 135, 110, 1'b1, 0, 4'b1110);
      shoot_a("shot_hitduck", 120, 110, 1'b0, 0, 4'b1110);
      shoot_a("shot2", 135, 110, 1'b1, 1, 4'b1100);
      shoot_a("shot_miss", 50, 50, 1'b0, 0, 4'b1100);
      pix_a_at("hitdraw", 160, 110, 490, 1'b1, 63, 1);
      pix_a_at("px93b", 101, 102, 93, 1'b1, 21, 0);

      @(posedge clk); #2; rst_a = 1'b0; #1;
      check("mid_alive", 32'(alive_a), 15);
      check("mid_draw", 32'(draw_a), 0);
      check("mid_pix", 32'(pix_a), 0);
      check("mid_addr", 32'(rom_addr_a), 0);
      check("mid_x0", dut_a.ch_x_s[0], 100);
      check("mid_y0", dut_a.ch_y_s[0], 100);

      @(negedge clk); rst_b = 1'b1;
      check("b_x0_spawn", dut_b.ch_x_s[0], 594);
`ifdef DUCK_MIRROR_EN
      check("b_x1_spawn", dut_b.ch_x_s[1], -166);
`else
      check("b_x1_spawn", dut_b.ch_x_s[1], 714);
`endif
      adv(4);
      check("b_x0_step1", dut_b.ch_x_s[0], 593);
`ifdef DUCK_MIRROR_EN
      check("b_x1_step1", dut_b.ch_x_s[1], -165);
`else
      check("b_x1_step1", dut_b.ch_x_s[1], 713);
`endif
      adv(4);
      check("b_x0_step2", dut_b.ch_x_s[0], 592);
      adv(2552);
      check("b_x0_edge", dut_b.ch_x_s[0], -46);
      adv(3);
      check("b_x0_hold", dut_b.ch_x_s[0], -46);
      adv(1);
      check("b_x0_wrap", dut_b.ch_x_s[0], 640);

      @(posedge clk); #3; rst_b = 1'b0; #1;
      check("b_rst_alive", 32'(alive_b), 15);
      check("b_rst_x0", dut_b.ch_x_s[0], 594);
      check("b_rst_y0", dut_b.ch_y_s[0], 150);

      @(negedge clk); rst_b = 1'b1;
      sv_b = 1'b1; sx_b = 10'd600; sy_b = 10'd160;
      adv(1);
      sv_b = 1'b0;
      check("b_hit_pulse", 32'(hp_b), 1);
      check("b_hit_id", 32'(hid_b), 0);
      check("b_hit_alive", 32'(alive_b), 14);
      adv(14);
      check("b_frozen_st", 32'(dut_b.ch_st_s[0]), 32'(ST_HIT));
      check("b_frozen_y", dut_b.ch_y_s[0], 150);
      adv(1);
      check("b_fall_st", 32'(dut_b.ch_st_s[0]), 32'(ST_FALL));
      adv(8);
      check("b_fall_y1", dut_b.ch_y_s[0], 152);
      adv(1311);
      check("b_fall_y478", dut_b.ch_y_s[0], 478);
      check("b_fall_st2", 32'(dut_b.ch_st_s[0]), 32'(ST_FALL));
      adv(1);
      check("b_fall_y480", dut_b.ch_y_s[0], 480);
      check("b_resp_st", 32'(dut_b.ch_st_s[0]), 32'(ST_RESP));
      adv(23);
      check("b_resp_alive", 32'(alive_b[0]), 0);
      adv(1);
      check("b_respawn_alive", 32'(alive_b[0]), 1);
      check("b_respawn_x", dut_b.ch_x_s[0], 594);
      check("b_respawn_y", dut_b.ch_y_s[0], 150);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
